// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bus bundle for the two-requester memory arbiter.
//   Requester A (core) and B (loader): x_req/x_we/x_lock/x_add/x_wdata in,
//   x_gnt/x_rvalid/x_rdata out, plus the sticky a_err flag.
//   RAM side: ram_en/ram_we/ram_add/ram_wdata out of the arbiter, ram_rdata
//   back one cycle after ram_en.
//   slave  : arbiter view.
//   master : requesters + RAM (environment) view.
interface mem_arbiter_if;
  logic        a_req, a_we, a_lock;
  logic [15:0] a_add, a_wdata;
  logic        b_req, b_we, b_lock;
  logic [15:0] b_add, b_wdata;
  logic        a_gnt, b_gnt;
  logic        a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        a_err;
  logic        ram_en, ram_we;
  logic [15:0] ram_add, ram_wdata, ram_rdata;

  modport slave (
    input  a_req, a_we, a_lock, a_add, a_wdata,
    input  b_req, b_we, b_lock, b_add, b_wdata,
    input  ram_rdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, a_err,
    output ram_en, ram_we, ram_add, ram_wdata
  );

  modport master (
    output a_req, a_we, a_lock, a_add, a_wdata,
    output b_req, b_we, b_lock, b_add, b_wdata,
    output ram_rdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, a_err,
    input  ram_en, ram_we, ram_add, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester single-port RAM arbiter.
//   clock_in : sole clock, rising edge.
//   reset_in : asynchronous active-high reset.
//   bus      : mem_arbiter_if.slave (requests, grants, read returns, RAM port).
// Grants are combinational. Round-robin on contention, optional lock to keep
// priority, burst limit MAX_BURST on locked grants while the other side waits.
// Requester A writes at or above PROT_BASE are accepted but suppressed and
// flagged in the sticky a_err.
module mem_arbiter #(
  parameter int          MAX_BURST = 8,
  parameter logic [15:0] PROT_BASE = 16'hfe00
) (
  input logic         clock_in,
  input logic         reset_in,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1: B was granted last
  logic [CW-1:0] cnt_q, cnt_d;         // consecutive locked grants
  logic          rd_a_q, rd_a_d;       // read return owner tags
  logic          rd_b_q, rd_b_d;
  logic          a_err_q, a_err_d;
  logic          gnt_a, gnt_b, burst_full, a_prot;

  assign burst_full = (cnt_q >= CW'(MAX_BURST));
  assign a_prot     = bus.a_we && (bus.a_add >= PROT_BASE);

  // Arbitration + next state
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    state_d  = IDLE;
    last_b_d = last_b_q;
    cnt_d    = '0;
    if (!reset_in) begin
      case (state_q)
        LOCK_A: begin
          if (bus.a_req) begin
            if (burst_full && bus.b_req) gnt_b = 1'b1;
            else                         gnt_a = 1'b1;
          end else begin
            gnt_b = bus.b_req;
          end
        end
        LOCK_B: begin
          if (bus.b_req) begin
            if (burst_full && bus.a_req) gnt_a = 1'b1;
            else                         gnt_b = 1'b1;
          end else begin
            gnt_a = bus.a_req;
          end
        end
        default: begin
          if (bus.a_req && bus.b_req) begin
            gnt_a = last_b_q;
            gnt_b = !last_b_q;
          end else begin
            gnt_a = bus.a_req;
            gnt_b = bus.b_req;
          end
        end
      endcase
    end

    // Counter saturates so an uncontested lock is never cut off, yet a
    // newly arriving requester is served at once after a long lock.
    if (gnt_a) begin
      last_b_d = 1'b0;
      if (bus.a_lock) begin
        state_d = LOCK_A;
        cnt_d   = (state_q != LOCK_A) ? CW'(1) :
                  burst_full ? cnt_q : cnt_q + CW'(1);
      end
    end else if (gnt_b) begin
      last_b_d = 1'b1;
      if (bus.b_lock) begin
        state_d = LOCK_B;
        cnt_d   = (state_q != LOCK_B) ? CW'(1) :
                  burst_full ? cnt_q : cnt_q + CW'(1);
      end
    end
  end

  // RAM port mux and read-tag / error next state
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_add   = '0;
    bus.ram_wdata = '0;
    if (gnt_a) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.a_we && !a_prot;
      bus.ram_add   = bus.a_add;
      bus.ram_wdata = bus.a_wdata;
    end else if (gnt_b) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.b_we;
      bus.ram_add   = bus.b_add;
      bus.ram_wdata = bus.b_wdata;
    end
  end

  assign rd_a_d  = gnt_a && !bus.a_we;
  assign rd_b_d  = gnt_b && !bus.b_we;
  assign a_err_d = a_err_q || (gnt_a && a_prot);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
      a_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      a_err_q  <= a_err_d;
    end
  end

  // Tags clear asynchronously, so outstanding reads vanish on reset.
  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = rd_a_q;
  assign bus.b_rvalid = rd_b_q;
  assign bus.a_rdata  = rd_a_q ? bus.ram_rdata : '0;
  assign bus.b_rdata  = rd_b_q ? bus.ram_rdata : '0;
  assign bus.a_err    = a_err_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester while the other requests.
REQ-002 SHALL provide parameter PROT_BASE, default 16'hfe00, lowest address requester A may not write.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clock_in  input  1  sole clock, all state on rising edge.
REQ-005 reset_in  input  1  asynchronous active-high reset.
REQ-006 a_req / b_req  input  1  access request from core (A) and loader (B).
REQ-007 a_we / b_we  input  1  1 = write, 0 = read; valid while x_req.
REQ-008 a_lock / b_lock  input  1  request to retain grant on following cycles.
REQ-009 a_add / b_add  input  16  word address; a_wdata / b_wdata  input  16  write data.
REQ-010 a_gnt / b_gnt  output  1  combinational grant, this cycle's access accepted.
REQ-011 a_rvalid / b_rvalid  output  1  read data valid, one cycle after granted read.
REQ-012 a_rdata / b_rdata  output  16  read data, valid only with x_rvalid, else 0.
REQ-013 a_err  output  1  sticky flag: A attempted write at address >= PROT_BASE.
REQ-014 ram_en, ram_we  output  1  RAM enable and write strobe.
REQ-015 ram_add, ram_wdata  output  16  RAM address and write data; ram_rdata  input  16, returned one cycle after ram_en.

Function
REQ-016 At most one of a_gnt, b_gnt SHALL be 1 in any cycle; grant only when the corresponding x_req is 1.
REQ-017 Single requester: granted same cycle, every cycle it requests (back-to-back, one access per cycle).
REQ-018 Both requesting, no lock held: round-robin; grant the requester not granted last; last register updates on each grant.
REQ-019 Lock: if granted requester asserts x_req & x_lock, it SHALL keep priority next cycle (state LOCK_A / LOCK_B), else state returns to IDLE.
REQ-020 Burst counter counts consecutive locked grants; when it reaches MAX_BURST and the other requester requests, grant SHALL pass to the other for at least one cycle; counter clears on release.
REQ-021 Lock with other side idle SHALL not be limited; counter saturates at MAX_BURST.
REQ-022 Granted cycle: ram_en=1, ram_add/ram_wdata/ram_we from winner; no grant: ram_en=0, ram_we=0, ram_add=0, ram_wdata=0.
REQ-023 A write with a_add >= PROT_BASE SHALL be granted, ram_we forced 0, ram_en 1, a_err set; B writes unrestricted.
REQ-024 Granted read SHALL register owner tag; next cycle drive owner x_rvalid=1, x_rdata=ram_rdata; writes produce no rvalid.
REQ-025 Read returns pipeline with new grants: back-to-back reads yield rvalid every cycle, owner per cycle matching grant order.
REQ-026 Requester SHALL hold x_add/x_we/x_wdata stable while x_req=1 and x_gnt=0; arbiter never latches request fields.

Reset
REQ-027 On reset_in=1: state IDLE, last=B (A wins first contention), burst counter 0, pending read tag cleared, a_err=0.
REQ-028 During reset all outputs 0; reset during an outstanding read SHALL suppress that read's rvalid.
REQ-029 First grant possible in first cycle after reset_in deasserts.

Verification
REQ-030 After reset, a_req=b_req=1 reads, no lock, 4 cycles -> grants A,B,A,B; rvalid follows one cycle later in same order.
REQ-031 B write b_add=16'h3000 b_wdata=16'h1234, then A read 16'h3000 -> ram_we=1 once; a_rvalid with a_rdata=16'h1234 one cycle after A grant.
REQ-032 A lock burst, b_req=1 throughout, MAX_BURST=8 -> a_gnt 8 consecutive cycles, then b_gnt 1 cycle, then A resumes.
REQ-033 A write a_add=16'hfe00 -> a_gnt=1, ram_we=0, a_err=1 and stays 1 until reset; A write 16'hfdff -> ram_we=1, a_err unchanged.
REQ-034 A read granted, reset_in pulsed next edge -> a_rvalid stays 0, all outputs 0, next contention grants A.
